// File: rtl/flash_program_controller.sv
// flash_program_controller: StrataFlash program / block-erase sequencer with status polling.
// Optional poll timeout enabled by defining TIMEOUT_EN.
module flash_program_controller #(
  parameter int WIDTH      = 8,
  parameter int ROM_ADDR   = 24,
  parameter int T_SU       = 2,
  parameter int T_WE       = 3,
  parameter int T_RD       = 4,
  parameter int POLL_LIMIT = 65535
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ROM_ADDR-1:0] addr,
  input  logic [WIDTH-1:0]    wdata,
  input  logic                prog,
  input  logic                erase,
  output logic                busy,
  output logic                done,
  output logic                error,
  output logic [7:0]          status,
  input  logic [WIDTH-1:0]    SF_D_I,
  output logic [WIDTH-1:0]    SF_D_O,
  output logic                SF_D_T,
  output logic [ROM_ADDR-1:0] SF_A,
  output logic                SF_CE0,
  output logic                SF_OE,
  output logic                SF_WE,
  output logic                SF_BYTE
);
  typedef enum logic [2:0] {IDLE, CMD1, CMD2, STAT_CMD, STAT_RD, CLR, ARRAY, DONE} state_t;
  typedef enum logic [2:0] {PH_SETUP, PH_PULSE, PH_HOLD, PH_RD, PH_REC} phase_t;
  state_t state_q, state_d, after_wr;
  phase_t phase_q, phase_d;
  logic [7:0] cnt_q, cnt_d, status_q, status_d;
  logic [ROM_ADDR-1:0] addr_q, addr_d;
  logic [WIDTH-1:0] wdata_q, wdata_d, wr_data;
  logic is_prog_q, is_prog_d, err_q, err_d, wr_st, rd_act, sr_err;
`ifdef TIMEOUT_EN
  logic [15:0] polls_q, polls_d;
`endif
  always_comb begin
    wr_st = state_q inside {CMD1, CMD2, STAT_CMD, CLR, ARRAY};
    rd_act = state_q == STAT_RD && phase_q == PH_RD;
    sr_err = status_q[5] | status_q[4] | status_q[3] | status_q[1];
    wr_data = state_q == CMD1 ? WIDTH'(is_prog_q ? 8'h40 : 8'h20) :
              state_q == CMD2 ? (is_prog_q ? wdata_q : WIDTH'(8'hD0)) :
              state_q == STAT_CMD ? WIDTH'(8'h70) :
              state_q == CLR ? WIDTH'(8'h50) : WIDTH'(8'hFF);
    after_wr = state_q == CMD1 ? CMD2 : state_q == CMD2 ? STAT_CMD :
               state_q == STAT_CMD ? STAT_RD : state_q == CLR ? ARRAY : DONE;
  end
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    cnt_d = cnt_q + 8'd1;
    addr_d = addr_q;
    wdata_d = wdata_q;
    is_prog_d = is_prog_q;
    err_d = err_q;
    status_d = status_q;
`ifdef TIMEOUT_EN
    polls_d = polls_q;
`endif
    if (state_q == IDLE) begin
      cnt_d = 8'd0;
      phase_d = PH_SETUP;
      if (prog || erase) begin
        state_d = CMD1;
        addr_d = addr;
        wdata_d = wdata;
        is_prog_d = prog;
        err_d = 1'b0;
        status_d = 8'h00;
`ifdef TIMEOUT_EN
        polls_d = 16'd0;
`endif
      end
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end else if (phase_q == PH_SETUP && cnt_q == 8'(T_SU - 1)) begin
      phase_d = PH_PULSE;
      cnt_d = 8'd0;
    end else if (phase_q == PH_PULSE && cnt_q == 8'(T_WE - 1)) begin
      phase_d = PH_HOLD;
      cnt_d = 8'd0;
    end else if (phase_q == PH_HOLD) begin
      state_d = after_wr;
      phase_d = after_wr == STAT_RD ? PH_RD : PH_SETUP;
      cnt_d = 8'd0;
    end else if (phase_q == PH_RD && cnt_q == 8'(T_RD - 1)) begin
      phase_d = PH_REC;
      status_d = SF_D_I[7:0];
`ifdef TIMEOUT_EN
      polls_d = polls_q + 16'd1;
`endif
    end else if (phase_q == PH_REC) begin
      // Recovery cycle doubles as the decision point on the sample just taken
      cnt_d = 8'd0;
      phase_d = PH_RD;
      if (status_q[7]) begin
        err_d = sr_err;
        state_d = sr_err ? CLR : ARRAY;
        phase_d = PH_SETUP;
      end
`ifdef TIMEOUT_EN
      else if (polls_q == 16'(POLL_LIMIT)) begin
        err_d = 1'b1;
        state_d = CLR;
        phase_d = PH_SETUP;
      end
`endif
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      phase_q <= PH_SETUP;
      cnt_q <= 8'd0;
      addr_q <= '0;
      wdata_q <= '0;
      is_prog_q <= 1'b0;
      err_q <= 1'b0;
      status_q <= 8'h00;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      cnt_q <= cnt_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      is_prog_q <= is_prog_d;
      err_q <= err_d;
      status_q <= status_d;
    end
  end
`ifdef TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) polls_q <= 16'd0;
    else polls_q <= polls_d;
  end
`endif
  assign busy = state_q != IDLE;
  assign done = state_q == DONE;
  assign error = done && err_q;
  assign status = status_q;
  assign SF_CE0 = !(wr_st || rd_act);
  assign SF_OE = !rd_act;
  assign SF_WE = !(wr_st && phase_q == PH_PULSE);
  assign SF_D_T = !wr_st;
  assign SF_D_O = wr_st ? wr_data : '0;
  assign SF_A = (state_q == IDLE || state_q == DONE) ? '0 : addr_q;
  assign SF_BYTE = WIDTH == 16;
endmodule

// File: tb/tb_flash_program_controller.sv
// tb_flash_program_controller: directed checks of program/erase sequences against a small flash model.
module tb_flash_program_controller;
  logic clk = 0, rst = 1, prog = 0, erase = 0;
  logic [23:0] addr = 0;
  logic [7:0] wdata = 0;
  logic busy, done, error, SF_D_T, SF_CE0, SF_OE, SF_WE, SF_BYTE;
  logic [7:0] status, SF_D_I, SF_D_O;
  logic [23:0] SF_A;
  int n_chk = 0, n_fail = 0, rd_cnt = 0, rd_base = 0, n_pre = 0, n_done = 0, cyc;
  logic [7:0] sr_pre, sr_fin, err_s, st_s;
  logic [23:0] la[$];
  logic [7:0] ld[$];

  flash_program_controller #(.POLL_LIMIT(5)) dut (
    .clk(clk), .rst(rst), .addr(addr), .wdata(wdata), .prog(prog), .erase(erase),
    .busy(busy), .done(done), .error(error), .status(status),
    .SF_D_I(SF_D_I), .SF_D_O(SF_D_O), .SF_D_T(SF_D_T), .SF_A(SF_A),
    .SF_CE0(SF_CE0), .SF_OE(SF_OE), .SF_WE(SF_WE), .SF_BYTE(SF_BYTE)
  );

  always #5 clk = ~clk;
  always @(posedge SF_WE) if (!rst) begin la.push_back(SF_A); ld.push_back(SF_D_O); end
  always @(posedge SF_OE) if (!rst) rd_cnt++;
  always @(posedge clk) if (done) n_done++;
  assign SF_D_I = (rd_cnt - rd_base < n_pre) ? sr_pre : sr_fin;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic run(input logic p, input logic e, input logic [23:0] a, input logic [7:0] d,
                     input int npre, input logic [7:0] pre, input logic [7:0] fin, input int hold);
    la.delete();
    ld.delete();
    rd_base = rd_cnt;
    n_pre = npre;
    sr_pre = pre;
    sr_fin = fin;
    @(negedge clk);
    prog = p; erase = e; addr = a; wdata = d;
    @(posedge clk);
    #1 prog = 0; erase = 0;
    check("busy_on_accept", busy, 1);
    cyc = -1;
    for (int i = 1; i <= 300; i++) begin
      @(posedge clk);
      #1;
      if (hold > 0) prog = (i >= 3 && i < 3 + hold);
      if (done) begin
        cyc = i;
        err_s = error;
        st_s = status;
        break;
      end
    end
    prog = 0;
    @(posedge clk);
    #1;
    check("done_one_cycle", done, 0);
    check("busy_after_done", busy, 0);
  endtask

  initial begin
    int d0;
    #2;
    check("rst_ce", SF_CE0, 1);
    check("rst_oe_we_dt", {SF_OE, SF_WE, SF_D_T}, 3'b111);
    check("rst_a_d", {SF_A, SF_D_O}, 0);
    check("rst_busy_done_err_st", {busy, done, error, status}, 0);
    check("sf_byte", SF_BYTE, 0);
    @(negedge clk) rst = 0;

    run(1, 0, 24'h000123, 8'hA5, 0, 8'h00, 8'h80, 0);
    check("p1_cycles", cyc, 29);
    check("p1_nwr", la.size(), 4);
    check("p1_w0", {la[0], ld[0]}, {24'h000123, 8'h40});
    check("p1_w1", {la[1], ld[1]}, {24'h000123, 8'hA5});
    check("p1_w2", {la[2], ld[2]}, {24'h000123, 8'h70});
    check("p1_w3", {la[3], ld[3]}, {24'h000123, 8'hFF});
    check("p1_reads", rd_cnt - rd_base, 1);
    check("p1_err_st", {err_s, st_s}, {8'h00, 8'h80});

    run(0, 1, 24'h020000, 8'h00, 3, 8'h00, 8'h80, 0);
    check("e_cycles", cyc, 44);
    check("e_nwr", la.size(), 4);
    check("e_w0", {la[0], ld[0]}, {24'h020000, 8'h20});
    check("e_w1", ld[1], 8'hD0);
    check("e_w2", ld[2], 8'h70);
    check("e_w3", ld[3], 8'hFF);
    check("e_reads", rd_cnt - rd_base, 4);
    check("e_err", err_s, 0);

    run(1, 0, 24'h00F00E, 8'h3C, 0, 8'h00, 8'h90, 0);
    check("pe_cycles", cyc, 35);
    check("pe_nwr", la.size(), 5);
    check("pe_w1", ld[1], 8'h3C);
    check("pe_w3_clr", ld[3], 8'h50);
    check("pe_w4", ld[4], 8'hFF);
    check("pe_err_st", {err_s, st_s}, {8'h01, 8'h90});

    d0 = n_done;
    run(1, 1, 24'h000456, 8'h11, 0, 8'h00, 8'h80, 8);
    repeat (40) @(posedge clk);
    #1;
    check("both_w0", ld[0], 8'h40);
    check("both_w1", ld[1], 8'h11);
    check("both_nwr", la.size(), 4);
    check("both_ndone", n_done - d0, 1);

    la.delete();
    ld.delete();
    d0 = n_done;
    @(negedge clk);
    prog = 1; addr = 24'h000777; wdata = 8'h55;
    @(posedge clk);
    #1 prog = 0;
    repeat (9) @(posedge clk);
    #1;
    check("rst_mid_pulse_we", SF_WE, 0);
    rst = 1;
    #1;
    check("rst_mid_strobes", {SF_WE, SF_CE0, SF_D_T, SF_OE}, 4'b1111);
    check("rst_mid_busy", busy, 0);
    @(negedge clk) rst = 0;
    repeat (40) @(posedge clk);
    #1;
    check("rst_mid_nwr", la.size(), 1);
    check("rst_mid_ndone", n_done - d0, 0);
    check("rst_mid_idle", {busy, SF_CE0}, 2'b01);

`ifdef TIMEOUT_EN
    run(1, 0, 24'h000321, 8'h77, 1000, 8'h00, 8'h00, 0);
    check("to_cycles", cyc, 55);
    check("to_reads", rd_cnt - rd_base, 5);
    check("to_nwr", la.size(), 5);
    check("to_w3_clr", ld[3], 8'h50);
    check("to_w4", ld[4], 8'hFF);
    check("to_err_st", {err_s, st_s}, {8'h01, 8'h00});
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
